// File: rtl/operand_loader_if.sv
// rtl/operand_loader_if.sv - byte stream in, operands/start/busy out
// Purpose: bundles the operand loader's byte stream and result signals.
// Signals: DIN/DIN_VALID/DIN_READY byte handshake; A/B/C assembled
//          operands; START one-cycle adder kick; BUSY hold-window flag.
// Modports: master = stream source / result consumer, slave = loader.
interface operand_loader_if #(
  parameter int WIDTH = 32
);
  logic [7:0]       DIN;
  logic             DIN_VALID;
  logic             DIN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic             START;
  logic             BUSY;

  modport master (
    output DIN, DIN_VALID,
    input  DIN_READY, A, B, C, START, BUSY
  );

  modport slave (
    input  DIN, DIN_VALID,
    output DIN_READY, A, B, C, START, BUSY
  );
endinterface

// File: rtl/operand_loader.sv
// rtl/operand_loader.sv - assembles A/B/C from a byte stream and kicks the serial adder
// Purpose: loads 3*WIDTH/8 little-endian bytes (A, then B, then C), pulses
//          START once, then freezes the operands for HOLD_CYCLES CE cycles.
// Ports: CLK clock; RESET async active-low reset; CE clock enable;
//        CLEAR synchronous abort back to LOAD; bus = operand_loader_if.slave.
module operand_loader #(
  parameter int WIDTH       = 32,
  parameter int HOLD_CYCLES = 36
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             CLEAR,
  operand_loader_if.slave  bus
);

  localparam int NBYTES = 3 * WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int HCW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0]  LAST_BYTE = CW'(NBYTES - 1);
  localparam logic [HCW-1:0] LAST_HOLD = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_FIRE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [HCW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [3*WIDTH-1:0]   ops_q, ops_d;   // {C, B, A}; byte k lands at bits 8k+7:8k
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hold_cnt_d = hold_cnt_q;
    ops_d      = ops_q;
    start_d    = start_q;
    busy_d     = busy_q;

    if (CE) begin
      case (state_q)
        ST_LOAD: begin
          // CLEAR wins over a byte offered on the same edge.
          if (CLEAR) begin
            byte_cnt_d = '0;
          end else if (bus.DIN_VALID) begin
            ops_d[{byte_cnt_q, 3'b000} +: 8] = bus.DIN;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = ST_FIRE;
              start_d    = 1'b1;
              busy_d     = 1'b1;
            end else begin
              byte_cnt_d = byte_cnt_q + 1'b1;
            end
          end
        end

        ST_FIRE: begin
          start_d = 1'b0;
          if (CLEAR) begin
            state_d = ST_LOAD;
            busy_d  = 1'b0;
          end else begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end

        ST_HOLD: begin
          if (CLEAR || (hold_cnt_q == LAST_HOLD)) begin
            state_d    = ST_LOAD;
            busy_d     = 1'b0;
            byte_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end

        default: begin
          state_d    = ST_LOAD;
          start_d    = 1'b0;
          busy_d     = 1'b0;
          byte_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_LOAD;
      byte_cnt_q <= '0;
      hold_cnt_q <= '0;
      ops_q      <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      ops_q      <= ops_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
    end
  end

  // Gated by RESET so READY is low during reset and high right after release.
  assign bus.DIN_READY = (state_q == ST_LOAD) && RESET;
  assign bus.A         = ops_q[WIDTH-1:0];
  assign bus.B         = ops_q[2*WIDTH-1:WIDTH];
  assign bus.C         = ops_q[3*WIDTH-1:2*WIDTH];
  assign bus.START     = start_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_operand_loader.sv
// tb/tb_operand_loader.sv - self-checking bench for operand_loader
module tb_operand_loader;

  localparam int WIDTH = 32;
  localparam int HOLD  = 36;
  localparam int LAT   = 1 + HOLD;

  logic CLK;
  logic RESET;
  logic CE;
  logic CLEAR;

  operand_loader_if #(.WIDTH(WIDTH)) bus ();

  operand_loader #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .CE    (CE),
    .CLEAR (CLEAR),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [95:0] sb[$];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard pop on START rise; busy-window length in CE cycles.
  logic start_prev = 1'b0;
  logic busy_prev  = 1'b0;
  int   busy_ce    = 0;
  bit   ready_bad  = 1'b0;
  bit   skip_busy  = 1'b0;

  always @(negedge CLK) begin
    if (bus.START && !start_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_start", 96'd1, 96'd0);
      end else begin
        logic [95:0] e;
        e = sb.pop_front();
        chk("operands_at_start", {bus.C, bus.B, bus.A}, e);
      end
    end
    if (bus.BUSY) begin
      if (CE) busy_ce++;
      if (bus.DIN_READY) ready_bad = 1'b1;
    end
    if (!bus.BUSY && busy_prev) begin
      if (!skip_busy) begin
        chk("busy_ce_cycles", 96'(busy_ce), 96'(LAT));
        chk("ready_low_in_busy", 96'(ready_bad), 96'd0);
      end
      busy_ce   = 0;
      ready_bad = 1'b0;
    end
    start_prev = bus.START;
    busy_prev  = bus.BUSY;
  end

  task automatic send_byte(input logic [7:0] b, input bit tog);
    int  n;
    bit  acc;
    n   = 0;
    acc = 1'b0;
    bus.DIN       = b;
    bus.DIN_VALID = 1'b1;
    do begin
      CE = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      acc = CE && bus.DIN_READY;
      @(posedge CLK);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("accept_timeout", 96'd0, 96'd1);
    bus.DIN_VALID = 1'b0;
    CE = 1'b1;
  endtask

  task automatic send_ops(input logic [95:0] ops, input int first, input bit tog);
    for (int k = first; k < 12; k++) send_byte(ops[8*k +: 8], tog);
  endtask

  // Counts CE-qualified edges until DIN_READY returns.
  task automatic wait_idle(input bit tog, output int n);
    int cyc;
    n   = 0;
    cyc = 0;
    do begin
      CE = tog ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      if (CE) n++;
      @(posedge CLK);
      #1;
      cyc++;
    end while (!bus.DIN_READY && cyc < 2000);
    if (!bus.DIN_READY) chk("idle_timeout", 96'd0, 96'd1);
    CE = 1'b1;
  endtask

  typedef struct {
    logic [31:0] a, b, c;
    bit          tog;
    logic [31:0] exp_a, exp_b, exp_c;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int lat;
    logic [95:0] ops;

    vecs[0] = '{32'h1, 32'h2, 32'h3, 1'b0, 32'h1, 32'h2, 32'h3};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[2] = '{32'h0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[3] = '{32'hA5A55A5A, 32'h80000001, 32'h7FFFFFFE, 1'b0, 32'hA5A55A5A, 32'h80000001, 32'h7FFFFFFE};
    vecs[4] = '{32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 1'b1, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};

    // Reset with random inputs
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      CE            = 1'($urandom_range(0, 1));
      CLEAR         = 1'($urandom_range(0, 1));
      bus.DIN       = 8'($urandom_range(0, 255));
      bus.DIN_VALID = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    chk("reset_abc", {bus.C, bus.B, bus.A}, 96'd0);
    chk("reset_start_busy_ready", {93'd0, bus.START, bus.BUSY, bus.DIN_READY}, 96'd0);
    CE = 1'b1; CLEAR = 1'b0; bus.DIN = 8'h00; bus.DIN_VALID = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("ready_after_release", 96'(bus.DIN_READY), 96'd1);

    // Table-driven sets
    for (int i = 0; i < 5; i++) begin
      sb.push_back({vecs[i].exp_c, vecs[i].exp_b, vecs[i].exp_a});
      send_ops({vecs[i].c, vecs[i].b, vecs[i].a}, 0, vecs[i].tog);
      wait_idle(vecs[i].tog, lat);
      chk($sformatf("latency_v%0d", i), 96'(lat), 96'(LAT));
    end

    // Backpressure: DIN_VALID held high through the hold window
    sb.push_back({32'h33333333, 32'h22222222, 32'h11111111});
    send_ops({32'h33333333, 32'h22222222, 32'h11111111}, 0, 1'b0);
    bus.DIN = 8'hAA; bus.DIN_VALID = 1'b1; CE = 1'b1;
    lat = 0;
    do begin
      @(posedge CLK);
      #1;
      lat++;
    end while (!bus.DIN_READY && lat < 200);
    chk("bp_latency", 96'(lat), 96'(LAT));
    chk("bp_a_unchanged", 96'(bus.A), 96'h11111111);
    @(posedge CLK);
    #1;
    bus.DIN_VALID = 1'b0;
    chk("bp_first_byte", 96'(bus.A), 96'h111111AA);
    ops = {32'h66666666, 32'h55555555, 32'h444444AA};
    sb.push_back(ops);
    send_ops(ops, 1, 1'b0);
    wait_idle(1'b0, lat);

    // Abort after 5 bytes; CLEAR drops a byte offered on the same edge
    send_byte(8'hDE, 1'b0); send_byte(8'hAD, 1'b0); send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0); send_byte(8'h77, 1'b0);
    CLEAR = 1'b1; bus.DIN = 8'h99; bus.DIN_VALID = 1'b1;
    @(posedge CLK);
    #1;
    CLEAR = 1'b0; bus.DIN_VALID = 1'b0;
    chk("abort_a_kept", 96'(bus.A), 96'hEFBEADDE);
    chk("abort_b_partial", 96'(bus.B), 96'h55555577);
    ops = {32'h99AABBCC, 32'h55667788, 32'h11223344};
    sb.push_back(ops);
    send_ops(ops, 0, 1'b0);
    wait_idle(1'b0, lat);
    chk("abort_set_latency", 96'(lat), 96'(LAT));

    // Reset mid-HOLD at hold count 10
    ops = {32'h0BADF00D, 32'h00C0FFEE, 32'hFEEDFACE};
    sb.push_back(ops);
    send_ops(ops, 0, 1'b0);
    repeat (11) @(posedge CLK);
    #1;
    skip_busy = 1'b1;
    RESET = 1'b0;
    #1;
    chk("midreset_abc", {bus.C, bus.B, bus.A}, 96'd0);
    chk("midreset_start_busy_ready", {93'd0, bus.START, bus.BUSY, bus.DIN_READY}, 96'd0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    chk("midreset_ready", 96'(bus.DIN_READY), 96'd1);
    @(negedge CLK);
    skip_busy = 1'b0;
    @(posedge CLK);
    #1;
    ops = {32'h01020304, 32'h05060708, 32'h090A0B0C};
    sb.push_back(ops);
    send_ops(ops, 0, 1'b0);
    wait_idle(1'b0, lat);
    chk("post_reset_latency", 96'(lat), 96'(LAT));

    repeat (3) @(posedge CLK);
    chk("scoreboard_empty", 96'(sb.size()), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
